trig_lookup_arbiter: RTL and testbench

Shares one cos_sin_lookup instance among NUM_REQ requesters: the map-sprite aim-dot generator, ball physics and the shot/putter controller.
- Grants at most one angle per cycle, round-robin, over a valid/ready handshake.
- Tracks the in-flight requester ID through the lookup pipeline.
- Returns the cos/sin magnitude and sign to the owning requester with fixed latency.
- Sits between the game logic and the single trig ROM, so each consumer no longer needs its own ROM copy.

---
 rtl/trig_lookup_arbiter_pkg.sv | 37 +++
 rtl/trig_lookup_arbiter_if.sv | 37 +++
 rtl/cos_sin_lookup.sv | 81 ++++++++
 rtl/trig_lookup_arbiter_rr_arbiter.sv | 51 +++++
 rtl/trig_lookup_arbiter.sv | 143 ++++++++++++++
 tb/tb_trig_lookup_arbiter.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/trig_lookup_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// trig_arb_pkg
// Shared constants and types for the trig lookup arbiter:
//   ANGLE_MAX  : largest legal angle in degrees; larger angles clamp to it
//   TRIG_ONE   : Q8 representation of 1.0
//   trig_rsp_t : cos/sin magnitude and sign bundle from the lookup
//   arb_tag_t  : in-flight tag carried alongside the lookup pipeline
// -----------------------------------------------------------------------------
package trig_arb_pkg;

    localparam int ANGLE_MAX  = 359;
    localparam int TRIG_ONE   = 256;
    localparam int LK_ANGLE_W = 9;
    localparam int RSP_W      = 16;
    localparam int ID_W       = 3;

    typedef struct packed {
        logic [RSP_W-1:0] cos_abs;
        logic [RSP_W-1:0] sin_abs;
        logic             cos_sign;
        logic             sin_sign;
    } trig_rsp_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } arb_tag_t;

    // Requester index after id, wrapping modulo n.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int n);
        if (int'(id) + 1 >= n) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/trig_lookup_arbiter_if.sv
// -----------------------------------------------------------------------------
// trig_lookup_arbiter_if
// Request/response bundle between the game-logic requesters and the arbiter.
//   req_valid_in / req_angle_in     : requester -> arbiter
//   req_ready_out                   : one-hot grant
//   rsp_valid_out                   : one-hot response strobe
//   rsp_cos/sin_abs_out, *_sign_out : shared response data
//   inflight_out                    : accepted but not yet answered
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface trig_lookup_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ANGLE_W = 16,
    parameter int TRIG_W  = 16
);
    logic [NUM_REQ-1:0]         req_valid_in;
    logic [NUM_REQ*ANGLE_W-1:0] req_angle_in;
    logic [NUM_REQ-1:0]         req_ready_out;
    logic [NUM_REQ-1:0]         rsp_valid_out;
    logic [TRIG_W-1:0]          rsp_cos_abs_out;
    logic [TRIG_W-1:0]          rsp_sin_abs_out;
    logic                       rsp_cos_sign_out;
    logic                       rsp_sin_sign_out;
    logic [3:0]                 inflight_out;

    modport master (
        output req_valid_in, req_angle_in,
        input  req_ready_out, rsp_valid_out, rsp_cos_abs_out, rsp_sin_abs_out,
               rsp_cos_sign_out, rsp_sin_sign_out, inflight_out
    );

    modport slave (
        input  req_valid_in, req_angle_in,
        output req_ready_out, rsp_valid_out, rsp_cos_abs_out, rsp_sin_abs_out,
               rsp_cos_sign_out, rsp_sin_sign_out, inflight_out
    );
endinterface

// File: rtl/cos_sin_lookup.sv
// -----------------------------------------------------------------------------
// cos_sin_lookup
// Quarter-wave Q8 sine ROM folded to full-circle |cos|/|sin| plus signs.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_angle        : angle in degrees, 0..359 (larger values clamp to 359)
//   o_rsp          : registered result, LOOKUP_LAT cycles after i_angle
// -----------------------------------------------------------------------------
module cos_sin_lookup
    import trig_arb_pkg::*;
#(
    parameter int LOOKUP_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [LK_ANGLE_W-1:0] i_angle,
    output trig_rsp_t             o_rsp
);

    // round(256 * sin(k deg)), k = 0..90
    localparam logic [8:0] SIN_TAB [0:90] = '{
        9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
        9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
        9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
        9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
        9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
        9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
        9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
        9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
        9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
        9'(TRIG_ONE)
    };

    logic [LK_ANGLE_W-1:0] w_a;
    logic [6:0]            w_sin_idx;
    logic [6:0]            w_cos_idx;
    trig_rsp_t             w_rsp;
    trig_rsp_t             r_pipe [LOOKUP_LAT];

    // Exact zeros (0/90/180/270) always report a positive sign.
    always_comb begin
        w_a = (i_angle > LK_ANGLE_W'(ANGLE_MAX)) ? LK_ANGLE_W'(ANGLE_MAX) : i_angle;
        w_sin_idx = '0;
        w_cos_idx = '0;
        w_rsp     = '0;
        if (w_a <= 9'd90) begin
            w_sin_idx = 7'(w_a);
            w_cos_idx = 7'(9'd90 - w_a);
        end else if (w_a <= 9'd180) begin
            w_sin_idx      = 7'(9'd180 - w_a);
            w_cos_idx      = 7'(w_a - 9'd90);
            w_rsp.cos_sign = 1'b1;
        end else if (w_a <= 9'd270) begin
            w_sin_idx      = 7'(w_a - 9'd180);
            w_cos_idx      = 7'(9'd270 - w_a);
            w_rsp.sin_sign = 1'b1;
            w_rsp.cos_sign = (w_a != 9'd270);
        end else begin
            w_sin_idx      = 7'(9'd360 - w_a);
            w_cos_idx      = 7'(w_a - 9'd270);
            w_rsp.sin_sign = 1'b1;
        end
        w_rsp.sin_abs = RSP_W'(SIN_TAB[w_sin_idx]);
        w_rsp.cos_abs = RSP_W'(SIN_TAB[w_cos_idx]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LOOKUP_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rsp;
            for (int i = 1; i < LOOKUP_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_rsp = r_pipe[LOOKUP_LAT-1];

endmodule

// File: rtl/trig_lookup_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   i_req      : request vector
//   i_ptr      : index with highest priority this cycle
//   o_grant    : one-hot grant (zero when nothing requests)
//   o_grant_id : index of the granted requester (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter
    import trig_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    int   w_dist;
    int   w_best_dist;
    int   w_best_idx;
    logic w_found;

    // Winner is the requester with the smallest wrapped distance from i_ptr.
    always_comb begin
        w_dist      = 0;
        w_best_dist = NUM_REQ;
        w_best_idx  = 0;
        w_found     = 1'b0;
        o_grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i]) begin
                w_dist = i - int'(i_ptr);
                if (w_dist < 0) begin
                    w_dist = w_dist + NUM_REQ;
                end
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_best_idx  = i;
                    w_found     = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = w_found && (w_best_idx == i);
        end
        o_grant_id = ID_W'(w_best_idx);
    end

endmodule

// File: rtl/trig_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// trig_lookup_arbiter
// Shares one cos_sin_lookup among NUM_REQ requesters. One grant per cycle,
// round-robin; the requester id rides a tag pipeline matched to the lookup
// latency so the result returns to its owner LOOKUP_LAT+2 cycles after the
// handshake.
//   pixel_clk_in : clock
//   rst_n_in     : async active-low reset (also forces req_ready_out low)
//   bus          : trig_lookup_arbiter_if.slave request/response bundle
// Build option: TRIG_ARB_PRIO0_EN gives requester 0 strict priority and keeps
// round-robin among the others; requester-0 grants do not move the pointer.
// -----------------------------------------------------------------------------
module trig_lookup_arbiter
    import trig_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ANGLE_W    = 16,
    parameter int TRIG_W     = 16,
    parameter int LOOKUP_LAT = 1
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    trig_lookup_arbiter_if.slave bus
);

    logic [ID_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]    w_rr_req;
    logic [NUM_REQ-1:0]    w_rr_grant;
    logic [ID_W-1:0]       w_rr_id;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gnt_id;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_hs;
    logic                  w_ptr_adv;
    logic [ANGLE_W-1:0]    w_angle_raw;
    logic [LK_ANGLE_W-1:0] w_angle_clamped;
    logic [LK_ANGLE_W-1:0] r_lk_angle;
    arb_tag_t              r_tag [0:LOOKUP_LAT];
    arb_tag_t              r_out_tag;
    trig_rsp_t             w_lk_rsp;
    trig_rsp_t             r_rsp;
    logic [3:0]            r_inflight;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .i_req      (w_rr_req),
        .i_ptr      (r_ptr),
        .o_grant    (w_rr_grant),
        .o_grant_id (w_rr_id)
    );

`ifdef TRIG_ARB_PRIO0_EN
    assign w_rr_req = bus.req_valid_in & ~NUM_REQ'(1);

    always_comb begin
        if (bus.req_valid_in[0]) begin
            w_grant  = NUM_REQ'(1);
            w_gnt_id = '0;
        end else begin
            w_grant  = w_rr_grant;
            w_gnt_id = w_rr_id;
        end
    end

    assign w_ptr_adv = w_hs && (w_gnt_id != '0);
`else
    assign w_rr_req  = bus.req_valid_in;
    assign w_grant   = w_rr_grant;
    assign w_gnt_id  = w_rr_id;
    assign w_ptr_adv = w_hs;
`endif

    // Grants are only a function of valid, so ready cannot loop back into valid.
    assign w_ready = w_grant & {NUM_REQ{rst_n_in}};
    assign w_hs    = |w_ready;

    always_comb begin
        w_angle_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_angle_raw = bus.req_angle_in[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    assign w_angle_clamped = (w_angle_raw > ANGLE_W'(ANGLE_MAX)) ? LK_ANGLE_W'(ANGLE_MAX)
                                                                : w_angle_raw[LK_ANGLE_W-1:0];

    cos_sin_lookup #(
        .LOOKUP_LAT (LOOKUP_LAT)
    ) u_lookup (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_n_in),
        .i_angle (r_lk_angle),
        .o_rsp   (w_lk_rsp)
    );

    // r_tag[LOOKUP_LAT] lines up with w_lk_rsp; both are registered once more.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr      <= '0;
            r_lk_angle <= '0;
            r_out_tag  <= '0;
            r_rsp      <= '0;
            r_inflight <= '0;
            for (int i = 0; i <= LOOKUP_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_ptr_adv) begin
                r_ptr <= next_id(w_gnt_id, NUM_REQ);
            end
            if (w_hs) begin
                r_lk_angle <= w_angle_clamped;
            end
            r_tag[0] <= '{valid: w_hs, id: w_gnt_id};
            for (int i = 1; i <= LOOKUP_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_out_tag  <= r_tag[LOOKUP_LAT];
            r_rsp      <= w_lk_rsp;
            r_inflight <= r_inflight + 4'(w_hs) - 4'(r_out_tag.valid);
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = r_out_tag.valid && (r_out_tag.id == ID_W'(i));
        end
    end

    assign bus.req_ready_out    = w_ready;
    assign bus.rsp_valid_out    = w_rsp_valid;
    assign bus.rsp_cos_abs_out  = TRIG_W'(r_rsp.cos_abs);
    assign bus.rsp_sin_abs_out  = TRIG_W'(r_rsp.sin_abs);
    assign bus.rsp_cos_sign_out = r_rsp.cos_sign;
    assign bus.rsp_sin_sign_out = r_rsp.sin_sign;
    assign bus.inflight_out     = r_inflight;

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trig_lookup_arbiter
// Bench for trig_lookup_arbiter: a behavioural model (integer pointer, queue of
// outstanding requests, real-valued trig) is compared against the DUT every
// cycle; directed scenarios pin grant order and response values to literals.
// -----------------------------------------------------------------------------
module tb_trig_lookup_arbiter;

    localparam int  N    = 3;
    localparam int  AW   = 16;
    localparam int  TW   = 16;
    localparam int  LAT  = 1;
    localparam real PI   = 3.14159265358979323846;

    typedef struct {
        int due;
        int id;
        int ang;
    } exp_t;

    logic clk;
    logic rst_n;

    trig_lookup_arbiter_if #(.NUM_REQ(N), .ANGLE_W(AW), .TRIG_W(TW)) bus();

    trig_lookup_arbiter #(
        .NUM_REQ    (N),
        .ANGLE_W    (AW),
        .TRIG_W     (TW),
        .LOOKUP_LAT (LAT)
    ) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_ptr = 0;
    int   max_inf = 0;
    int   n_strobe = 0;
    exp_t q[$];
    int   glog[$];
    int   last_rsp_cyc, last_rv, last_cos, last_sin, last_cs, last_ss;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
`ifdef TRIG_ARB_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i = (p + k) % N;
            if (i != 0 && v[i]) return i;
        end
`else
        for (int k = 0; k < N; k++) begin
            int i = (p + k) % N;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int q8(input real x);
        real ax = (x < 0.0) ? -x : x;
        return $rtoi(256.0 * ax + 0.5);
    endfunction

    function automatic int exp_cos(input int a); return q8($cos(a * PI / 180.0)); endfunction
    function automatic int exp_sin(input int a); return q8($sin(a * PI / 180.0)); endfunction
    function automatic int exp_cs(input int a);  return (a > 90 && a < 270) ? 1 : 0; endfunction
    function automatic int exp_ss(input int a);  return (a > 180) ? 1 : 0; endfunction

    always @(negedge clk) begin
        int   g, exp_ready, exp_rv, act_g, a;
        exp_t e;
        cyc++;
        if (bus.rsp_valid_out != '0) n_strobe++;
        if (!rst_n) begin
            q.delete();
            m_ptr = 0;
            chk("rst_ready", int'(bus.req_ready_out), 0);
            chk("rst_rsp_valid", int'(bus.rsp_valid_out), 0);
            chk("rst_inflight", int'(bus.inflight_out), 0);
            chk("rst_cos_abs", int'(bus.rsp_cos_abs_out), 0);
            chk("rst_sin_abs", int'(bus.rsp_sin_abs_out), 0);
        end else begin
            g = model_grant(bus.req_valid_in, m_ptr);
            exp_ready = (g < 0) ? 0 : (1 << g);
            chk("ready", int'(bus.req_ready_out), exp_ready);
            chk("inflight", int'(bus.inflight_out), q.size());
            if (int'(bus.inflight_out) > max_inf) max_inf = int'(bus.inflight_out);
            exp_rv = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv = 1 << e.id;
                chk("cos_abs", int'(bus.rsp_cos_abs_out), exp_cos(e.ang));
                chk("sin_abs", int'(bus.rsp_sin_abs_out), exp_sin(e.ang));
                chk("cos_sign", int'(bus.rsp_cos_sign_out), exp_cs(e.ang));
                chk("sin_sign", int'(bus.rsp_sin_sign_out), exp_ss(e.ang));
            end
            chk("rsp_valid", int'(bus.rsp_valid_out), exp_rv);
            if (bus.rsp_valid_out != '0) begin
                last_rsp_cyc = cyc;
                last_rv  = int'(bus.rsp_valid_out);
                last_cos = int'(bus.rsp_cos_abs_out);
                last_sin = int'(bus.rsp_sin_abs_out);
                last_cs  = int'(bus.rsp_cos_sign_out);
                last_ss  = int'(bus.rsp_sin_sign_out);
            end
            act_g = -1;
            for (int i = 0; i < N; i++) if (bus.req_ready_out[i]) act_g = i;
            if (act_g >= 0) glog.push_back(act_g);
            if (g >= 0) begin
                a = int'(bus.req_angle_in[g*AW +: AW]);
                if (a > 359) a = 359;
                q.push_back('{due: cyc + LAT + 2, id: g, ang: a});
`ifdef TRIG_ARB_PRIO0_EN
                if (g != 0) m_ptr = (g + 1) % N;
`else
                m_ptr = (g + 1) % N;
`endif
            end
        end
    end

    task automatic single(input int id, input int ang, input int c_abs, input int c_s,
                          input int s_abs, input int s_s);
        int issue, got;
        @(posedge clk); #1;
        bus.req_valid_in = N'(1 << id);
        bus.req_angle_in[id*AW +: AW] = AW'(ang);
        @(negedge clk); #1;
        issue = cyc;
        last_rsp_cyc = -1;
        @(posedge clk); #1;
        bus.req_valid_in = '0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk); #1;
            if (last_rsp_cyc >= 0) got = 1;
        end
        chk($sformatf("rsp_seen_a%0d", ang), got, 1);
        if (got) begin
            chk($sformatf("latency_a%0d", ang), last_rsp_cyc - issue, LAT + 2);
            chk($sformatf("owner_a%0d", ang), last_rv, 1 << id);
            chk($sformatf("cos_abs_a%0d", ang), last_cos, c_abs);
            chk($sformatf("cos_sign_a%0d", ang), last_cs, c_s);
            chk($sformatf("sin_abs_a%0d", ang), last_sin, s_abs);
            chk($sformatf("sin_sign_a%0d", ang), last_ss, s_s);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_fair [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`ifdef TRIG_ARB_PRIO0_EN
        int exp_alt [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
`else
        int exp_alt [8] = '{0, 1, 2, 1, 2, 1, 2, 1};
`endif
        int s0;
        rst_n = 1'b0;
        bus.req_valid_in = '1;
        bus.req_angle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog.delete();
        max_inf = 0;
        repeat (9) @(posedge clk);
        #1;
        bus.req_valid_in = '0;
        repeat (5) @(posedge clk);
        chk("fair_len", glog.size(), 9);
        for (int i = 0; i < 9 && i < glog.size(); i++) chk($sformatf("fair_grant%0d", i), glog[i], exp_fair[i]);
        chk("inflight_max", max_inf, LAT + 2);

        single(1, 0,   256, 0, 0,   0);
        single(1, 180, 256, 1, 0,   0);
        single(2, 400, 256, 0, 4,   1);
        single(0, 90,  0,   0, 256, 0);
        single(2, 45,  181, 0, 181, 0);
        single(0, 225, 181, 1, 181, 1);

        @(posedge clk); #1;
        glog.delete();
        bus.req_valid_in = 3'b010;
        repeat (5) @(posedge clk);
        #1;
        bus.req_valid_in = '0;
        chk("solo_len", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) chk($sformatf("solo_grant%0d", i), glog[i], 1);

        repeat (4) @(posedge clk);
        #1;
        bus.req_valid_in = 3'b010;
        bus.req_angle_in[1*AW +: AW] = 16'd30;
        @(posedge clk); #1;
        bus.req_valid_in = 3'b100;
        bus.req_angle_in[2*AW +: AW] = 16'd60;
        @(posedge clk); #1;
        bus.req_valid_in = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_strobe;
        repeat (6) @(posedge clk);
        #1;
        chk("midflight_strobes", n_strobe - s0, 0);
        chk("midflight_inflight", int'(bus.inflight_out), 0);

        reset_pulse();
        glog.delete();
        for (int c = 0; c < 8; c++) begin
            bus.req_valid_in = (c % 2 == 0) ? 3'b111 : 3'b110;
            @(posedge clk); #1;
        end
        bus.req_valid_in = '0;
        chk("alt_len", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk($sformatf("alt_grant%0d", i), glog[i], exp_alt[i]);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            for (int i = 0; i < N; i++) begin
                bus.req_valid_in[i] = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 9) == 0)
                    bus.req_angle_in[i*AW +: AW] = AW'($urandom_range(360, 65535));
                else
                    bus.req_angle_in[i*AW +: AW] = AW'($urandom_range(0, 359));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid_in = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_inflight", int'(bus.inflight_out), 0);
        chk("drain_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
